mem_port_arbiter: RTL and testbench

Shares the core's single memory port between instruction fetch and the load/store path of the execute stage. Arbitrates, sequences one outstanding memory transaction at a time, generates byte enables, and returns load data already extracted and sign/zero-extended. The execute stage and fetch unit stall on their own `ready` signals.

---
 rtl/core_pkg.sv | 25 ++
 rtl/lane_align.sv | 66 ++++++
 rtl/mem_port_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared encodings for the core memory path: access sizes, arbiter states
// and the alignment rule for load/store accesses.
package core_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_IF   = 2'd1,
        ARB_LS   = 2'd2
    } arb_state_e;

    // Size 11 is illegal and therefore always reported as an error.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return offset[0];
            SZ_W:    return offset != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lane_align.sv
// Byte-lane steering for the big-endian memory port: store placement with byte
// enables, and load lane extraction with sign/zero extension.
module lane_align
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      st_size,
    input  logic [1:0]      st_offset,
    input  logic [XLEN-1:0] st_wdata,
    output logic [3:0]      st_be,
    output logic [XLEN-1:0] st_lane_data,
    input  logic [1:0]      ld_size,
    input  logic [1:0]      ld_offset,
    input  logic            ld_unsigned,
    input  logic [XLEN-1:0] ld_rdata,
    output logic [XLEN-1:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_be        = '0;
        st_lane_data = '0;
        case (st_size)
            SZ_B: begin
                st_be        = 4'b1000 >> st_offset;
                st_lane_data = {st_wdata[7:0], 24'b0} >> {st_offset, 3'b000};
            end
            SZ_H: begin
                st_be        = st_offset[1] ? 4'b0011 : 4'b1100;
                st_lane_data = st_offset[1] ? {16'b0, st_wdata[15:0]} : {st_wdata[15:0], 16'b0};
            end
            SZ_W: begin
                st_be        = 4'b1111;
                st_lane_data = st_wdata;
            end
            default: begin
                st_be        = '0;
                st_lane_data = '0;
            end
        endcase
    end

    // Lane 0 sits in the most significant byte of the bus.
    always_comb begin
        ld_byte = ld_rdata[31:24];
        case (ld_offset)
            2'd0:    ld_byte = ld_rdata[31:24];
            2'd1:    ld_byte = ld_rdata[23:16];
            2'd2:    ld_byte = ld_rdata[15:8];
            default: ld_byte = ld_rdata[7:0];
        endcase
        ld_half = ld_offset[1] ? ld_rdata[15:0] : ld_rdata[31:16];

        ld_data = '0;
        case (ld_size)
            SZ_B:    ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
            SZ_H:    ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
            SZ_W:    ld_data = ld_rdata;
            default: ld_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store: arbitrates,
// runs one transaction at a time, and returns aligned, extended load data.
module mem_port_arbiter
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_ready,
    output logic [XLEN-1:0] if_rdata,
    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [1:0]      ls_size,
    input  logic            ls_unsigned,
    input  logic [XLEN-1:0] ls_addr,
    input  logic [XLEN-1:0] ls_wdata,
    output logic            ls_ready,
    output logic [XLEN-1:0] ls_rdata,
    output logic            ls_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam logic [XLEN-1:0] WORD_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    arb_state_e      state_q, state_d;
    logic            ls_streak_q, ls_streak_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]      mem_be_q, mem_be_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]      size_q, size_d;
    logic [1:0]      offset_q, offset_d;
    logic            unsigned_q, unsigned_d;
    logic            if_ready_q, if_ready_d;
    logic [XLEN-1:0] if_rdata_q, if_rdata_d;
    logic            ls_ready_q, ls_ready_d;
    logic            ls_err_q, ls_err_d;
    logic [XLEN-1:0] ls_rdata_q, ls_rdata_d;

    logic            if_pend, ls_pend, ls_bad, idle;
    logic            reject_ls, grant_ls, grant_if, ack_if, ack_ls;
    logic [3:0]      st_be;
    logic [XLEN-1:0] st_lane_data, ld_data;

    lane_align #(.XLEN(XLEN)) u_lane_align (
        .st_size      (ls_size),
        .st_offset    (ls_addr[1:0]),
        .st_wdata     (ls_wdata),
        .st_be        (st_be),
        .st_lane_data (st_lane_data),
        .ld_size      (size_q),
        .ld_offset    (offset_q),
        .ld_unsigned  (unsigned_q),
        .ld_rdata     (mem_rdata),
        .ld_data      (ld_data)
    );

    // A requester still showing its ready pulse has not yet dropped req.
    assign if_pend   = if_req & ~if_ready_q;
    assign ls_pend   = ls_req & ~ls_ready_q;
    assign ls_bad    = ls_pend & is_misaligned(ls_size, ls_addr[1:0]);
    assign idle      = (state_q == ARB_IDLE);
    assign reject_ls = idle & ls_bad;
    assign grant_ls  = idle & ls_pend & ~ls_bad & ~(if_pend & ls_streak_q);
    assign grant_if  = idle & if_pend & ~reject_ls & ~grant_ls;
    assign ack_if    = (state_q == ARB_IF) & mem_ack;
    assign ack_ls    = (state_q == ARB_LS) & mem_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            ls_streak_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ls_streak_q <= ls_streak_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ls_streak_d = ls_streak_q;
        case (state_q)
            ARB_IDLE: begin
                if (grant_ls)      state_d = ARB_LS;
                else if (grant_if) state_d = ARB_IF;
            end
            ARB_IF:  if (mem_ack) state_d = ARB_IDLE;
            ARB_LS:  if (mem_ack) state_d = ARB_IDLE;
            default: state_d = ARB_IDLE;
        endcase
        if (grant_ls && if_pend) ls_streak_d = 1'b1;
        if (grant_if)            ls_streak_d = 1'b0;
    end

    always_comb begin
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        size_d      = size_q;
        offset_d    = offset_q;
        unsigned_d  = unsigned_q;
        if_ready_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        ls_ready_d  = 1'b0;
        ls_err_d    = 1'b0;
        ls_rdata_d  = ls_rdata_q;

        if (grant_ls) begin
            mem_req_d   = 1'b1;
            mem_we_d    = ls_we;
            mem_addr_d  = ls_addr & WORD_MASK;
            mem_be_d    = st_be;
            mem_wdata_d = st_lane_data;
            size_d      = ls_size;
            offset_d    = ls_addr[1:0];
            unsigned_d  = ls_unsigned;
        end
        if (grant_if) begin
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr & WORD_MASK;
            mem_be_d    = 4'b1111;
            mem_wdata_d = '0;
        end
        if (reject_ls) begin
            ls_ready_d = 1'b1;
            ls_err_d   = 1'b1;
            ls_rdata_d = '0;
        end
        if (ack_if) begin
            mem_req_d  = 1'b0;
            if_ready_d = 1'b1;
            if_rdata_d = mem_rdata;
        end
        if (ack_ls) begin
            mem_req_d  = 1'b0;
            ls_ready_d = 1'b1;
            ls_rdata_d = mem_we_q ? '0 : ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            size_q      <= '0;
            offset_q    <= '0;
            unsigned_q  <= 1'b0;
            if_ready_q  <= 1'b0;
            if_rdata_q  <= '0;
            ls_ready_q  <= 1'b0;
            ls_err_q    <= 1'b0;
            ls_rdata_q  <= '0;
        end else begin
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            size_q      <= size_d;
            offset_q    <= offset_d;
            unsigned_q  <= unsigned_d;
            if_ready_q  <= if_ready_d;
            if_rdata_q  <= if_rdata_d;
            ls_ready_q  <= ls_ready_d;
            ls_err_q    <= ls_err_d;
            ls_rdata_q  <= ls_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ready  = if_ready_q;
    assign if_rdata  = if_rdata_q;
    assign ls_ready  = ls_ready_q;
    assign ls_err    = ls_err_q;
    assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, multi-cycle
// corner sequences, and randomized load/store traffic against a byte-level model.
module tb_mem_port_arbiter;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        ls_req, ls_we, ls_unsigned;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr, ls_wdata;
    logic        ls_ready, ls_err;
    logic [31:0] ls_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        resp_ack, man_ack;
    logic [31:0] resp_rdata;

    assign mem_ack   = resp_ack | man_ack;
    assign mem_rdata = resp_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_unsigned(ls_unsigned),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_ready(ls_ready), .ls_rdata(ls_rdata),
        .ls_err(ls_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    // Byte-addressed memory: mem_b is what the DUT writes, ref_b follows store semantics.
    logic [7:0] mem_b [logic [31:0]];
    logic [7:0] ref_b [logic [31:0]];

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        logic [31:0] h;
        h = a * 32'h9E3779B1;
        return h[23:16];
    endfunction
    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        return mem_b.exists(a) ? mem_b[a] : init_byte(a);
    endfunction
    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_b.exists(a) ? ref_b[a] : init_byte(a);
    endfunction
    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return {ref_rd(a), ref_rd(a + 32'd1), ref_rd(a + 32'd2), ref_rd(a + 32'd3)};
    endfunction
    function automatic void preload(input logic [31:0] wa, input logic [31:0] w);
        for (int unsigned k = 0; k < 4; k++) begin
            mem_b[wa + k] = 8'(w >> (24 - 8 * k));
            ref_b[wa + k] = 8'(w >> (24 - 8 * k));
        end
    endfunction

    function automatic int unsigned nbytes(input logic [1:0] sz);
        return (sz == SZ_B) ? 1 : (sz == SZ_H) ? 2 : 4;
    endfunction
    function automatic logic ref_err(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'b11) || ((a % nbytes(sz)) != 0);
    endfunction
    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
        logic [63:0] v;
        int unsigned n;
        n = nbytes(sz);
        v = '0;
        for (int unsigned i = 0; i < n; i++) v = (v << 8) | {56'b0, ref_rd(a + i)};
        if (!uns && ((v >> (8 * n - 1)) & 64'd1) != 0) v = v | ~((64'd1 << (8 * n)) - 64'd1);
        return v[31:0];
    endfunction
    function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [31:0] a);
        logic [3:0] be;
        be = '0;
        for (int unsigned i = 0; i < nbytes(sz); i++) be = be | (4'b1000 >> (a % 4 + i));
        return be;
    endfunction
    function automatic logic [31:0] ref_lane(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] w;
        int unsigned n;
        n = nbytes(sz);
        w = '0;
        for (int unsigned i = 0; i < n; i++)
            w = w | ({24'b0, 8'(wd >> (8 * (n - 1 - i)))} << (8 * (3 - (a % 4 + i))));
        return w;
    endfunction
    function automatic void ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int unsigned n;
        n = nbytes(sz);
        for (int unsigned i = 0; i < n; i++) ref_b[a + i] = 8'(wd >> (8 * (n - 1 - i)));
    endfunction
    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // Memory responder: acks after wait_cycles, checks request stability, logs transactions.
    int unsigned wait_cycles = 0;
    bit          resp_en = 1'b1;
    int unsigned txn_cnt = 0;
    logic        last_we;
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_be;
    logic [31:0] txn_addrs [$];

    initial begin
        int unsigned cnt;
        logic [31:0] a0, wd0;
        logic [3:0]  be0;
        logic        we0;
        resp_ack = 1'b0; resp_rdata = '0; cnt = 0;
        a0 = '0; wd0 = '0; be0 = '0; we0 = 1'b0;
        forever begin
            @(negedge clk);
            resp_ack = 1'b0;
            if (mem_req && !reset) begin
                if (cnt == 0) begin
                    a0 = mem_addr; be0 = mem_be; we0 = mem_we; wd0 = mem_wdata;
                end else begin
                    check32("mem_hold_addr", mem_addr, a0);
                    check32("mem_hold_ctl", {27'b0, mem_we, mem_be}, {27'b0, we0, be0});
                    check32("mem_hold_wdata", mem_wdata, wd0);
                end
                cnt++;
                if (resp_en && cnt > wait_cycles) begin
                    resp_ack   = 1'b1;
                    resp_rdata = {mem_rd(mem_addr), mem_rd(mem_addr + 32'd1),
                                  mem_rd(mem_addr + 32'd2), mem_rd(mem_addr + 32'd3)};
                    if (mem_we)
                        for (int unsigned k = 0; k < 4; k++)
                            if ((mem_be & (4'b1000 >> k)) != 0)
                                mem_b[mem_addr + k] = 8'(mem_wdata >> (24 - 8 * k));
                    last_we = mem_we; last_addr = mem_addr; last_be = mem_be; last_wdata = mem_wdata;
                    txn_addrs.push_back(mem_addr);
                    txn_cnt++;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic do_ls(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic err,
                         output int unsigned lat, output int unsigned ntx);
        int unsigned t0;
        t0 = txn_cnt;
        ls_req = 1'b1; ls_we = we; ls_size = sz; ls_unsigned = uns; ls_addr = a; ls_wdata = wd;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ls_ready && lat < 40);
        if (!ls_ready) check1("ls_timeout", 1'b0, 1'b1);
        rd = ls_rdata; err = ls_err; ntx = txn_cnt - t0;
        ls_req = 1'b0; ls_we = 1'b0;
    endtask

    task automatic do_if(input logic [31:0] a, output logic [31:0] rd, output int unsigned lat);
        if_req = 1'b1; if_addr = a; lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!if_ready && lat < 40);
        if (!if_ready) check1("if_timeout", 1'b0, 1'b1);
        rd = if_rdata;
        if_req = 1'b0;
    endtask

    task automatic gap(input logic [31:0] ls_hold, input logic [31:0] if_hold);
        @(posedge clk); #1;
        check1("ls_ready_pulse", ls_ready, 1'b0);
        check1("if_ready_pulse", if_ready, 1'b0);
        check32("ls_rdata_hold", ls_rdata, ls_hold);
        check32("if_rdata_hold", if_rdata, if_hold);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] mem_word;
        logic        exp_err;
        logic [3:0]  exp_be;
        logic [31:0] exp_lane;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vt [15];

    initial begin : main
        logic [31:0] rd, ird;
        logic        err;
        int unsigned lat, ntx, s0;
        time         p0;

        vt[0]  = '{1'b0, SZ_B,  1'b0, 32'h103, 32'h0,        32'h11223380, 1'b0, 4'b0001, 32'h0,        32'hFFFFFF80};
        vt[1]  = '{1'b0, SZ_B,  1'b1, 32'h103, 32'h0,        32'h11223380, 1'b0, 4'b0001, 32'h0,        32'h00000080};
        vt[2]  = '{1'b1, SZ_H,  1'b0, 32'h202, 32'h0000ABCD, 32'h0,        1'b0, 4'b0011, 32'h0000ABCD, 32'h0};
        vt[3]  = '{1'b0, SZ_W,  1'b0, 32'h101, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
        vt[4]  = '{1'b0, SZ_H,  1'b0, 32'h300, 32'h0,        32'h80011234, 1'b0, 4'b1100, 32'h0,        32'hFFFF8001};
        vt[5]  = '{1'b0, SZ_H,  1'b1, 32'h302, 32'h0,        32'h1234F00D, 1'b0, 4'b0011, 32'h0,        32'h0000F00D};
        vt[6]  = '{1'b0, SZ_W,  1'b0, 32'h400, 32'h0,        32'hDEADBEEF, 1'b0, 4'b1111, 32'h0,        32'hDEADBEEF};
        vt[7]  = '{1'b1, SZ_B,  1'b0, 32'h501, 32'h123456A5, 32'h0,        1'b0, 4'b0100, 32'h00A50000, 32'h0};
        vt[8]  = '{1'b1, SZ_W,  1'b0, 32'h600, 32'hCAFEF00D, 32'h0,        1'b0, 4'b1111, 32'hCAFEF00D, 32'h0};
        vt[9]  = '{1'b0, SZ_H,  1'b0, 32'h201, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
        vt[10] = '{1'b0, 2'b11, 1'b0, 32'h700, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
        vt[11] = '{1'b0, SZ_B,  1'b0, 32'h100, 32'h0,        32'h7F000000, 1'b0, 4'b1000, 32'h0,        32'h0000007F};
        vt[12] = '{1'b1, SZ_H,  1'b0, 32'h800, 32'h00001234, 32'h0,        1'b0, 4'b1100, 32'h12340000, 32'h0};
        vt[13] = '{1'b0, SZ_B,  1'b0, 32'h102, 32'h0,        32'h11223380, 1'b0, 4'b0010, 32'h0,        32'h00000033};
        vt[14] = '{1'b0, SZ_H,  1'b0, 32'h302, 32'h0,        32'h1234F00D, 1'b0, 4'b0011, 32'h0,        32'hFFFFF00D};

        reset = 1'b1; man_ack = 1'b0;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_size = '0; ls_unsigned = 1'b0; ls_addr = '0; ls_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check1("rst_mem_req", mem_req, 1'b0);
        check1("rst_mem_we", mem_we, 1'b0);
        check32("rst_mem_be", {28'b0, mem_be}, 32'h0);
        check32("rst_mem_addr", mem_addr, 32'h0);
        check32("rst_mem_wdata", mem_wdata, 32'h0);
        check1("rst_if_ready", if_ready, 1'b0);
        check1("rst_ls_ready", ls_ready, 1'b0);
        check1("rst_ls_err", ls_err, 1'b0);
        check32("rst_if_rdata", if_rdata, 32'h0);
        check32("rst_ls_rdata", ls_rdata, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed vector table, zero-wait memory.
        foreach (vt[i]) begin
            preload(vt[i].addr & 32'hFFFF_FFFC, vt[i].mem_word);
            do_ls(vt[i].we, vt[i].sz, vt[i].uns, vt[i].addr, vt[i].wd, rd, err, lat, ntx);
            check1("vec_err", err, vt[i].exp_err);
            check32("vec_rdata", rd, vt[i].exp_rd);
            check32("vec_latency", lat, vt[i].exp_err ? 32'd1 : 32'd2);
            check32("vec_txns", ntx, vt[i].exp_err ? 32'd0 : 32'd1);
            if (!vt[i].exp_err) begin
                check32("vec_be", {28'b0, last_be}, {28'b0, vt[i].exp_be});
                check32("vec_addr", last_addr, vt[i].addr & 32'hFFFF_FFFC);
                check1("vec_we", last_we, vt[i].we);
                if (vt[i].we) begin
                    check32("vec_wdata", last_wdata & be_mask(vt[i].exp_be), vt[i].exp_lane);
                    ref_store(vt[i].sz, vt[i].addr, vt[i].wd);
                end
            end
            gap(vt[i].exp_rd, if_rdata);
        end

        // Fetch, zero wait then three wait cycles.
        do_if(32'h1000, ird, lat);
        check32("if_latency", lat, 32'd2);
        check32("if_rdata", ird, ref_word(32'h1000));
        check32("if_be", {27'b0, last_we, last_be}, {27'b0, 1'b0, 4'b1111});
        gap(ls_rdata, ird);
        wait_cycles = 3;
        do_if(32'h1040, ird, lat);
        check32("if_wait_latency", lat, 32'd5);
        check32("if_wait_rdata", ird, ref_word(32'h1040));
        check32("if_wait_addr", last_addr, 32'h1040);
        wait_cycles = 0;
        gap(ls_rdata, ird);

        // Both requesters continuously: strict alternation starting with LS.
        s0 = txn_cnt;
        p0 = $time;
        fork
            begin : ls_side
                int unsigned k, guard;
                k = 0; guard = 0;
                ls_req = 1'b1; ls_we = 1'b0; ls_size = SZ_W; ls_unsigned = 1'b0; ls_addr = 32'h3000;
                while (k < 6 && guard < 200) begin
                    @(posedge clk); #1;
                    guard++;
                    if (ls_ready) begin
                        check32("arb_ls_cycle", 32'(($time - p0) / 10), 2 + 4 * k);
                        check32("arb_ls_rdata", ls_rdata, ref_word(ls_addr));
                        k++;
                        ls_addr = 32'h3000 + 4 * k;
                        if (k == 6) ls_req = 1'b0;
                    end
                end
                if (k < 6) check1("arb_ls_timeout", 1'b0, 1'b1);
            end
            begin : if_side
                int unsigned k, guard;
                k = 0; guard = 0;
                if_req = 1'b1; if_addr = 32'h1100;
                while (k < 6 && guard < 200) begin
                    @(posedge clk); #1;
                    guard++;
                    if (if_ready) begin
                        check32("arb_if_cycle", 32'(($time - p0) / 10), 4 + 4 * k);
                        check32("arb_if_rdata", if_rdata, ref_word(if_addr));
                        k++;
                        if_addr = 32'h1100 + 4 * k;
                        if (k == 6) if_req = 1'b0;
                    end
                end
                if (k < 6) check1("arb_if_timeout", 1'b0, 1'b1);
            end
        join
        check32("arb_txn_count", txn_cnt - s0, 32'd12);
        for (int unsigned j = 0; j < 12; j++)
            if (s0 + j < txn_addrs.size())
                check32("arb_order", txn_addrs[s0 + j], (j % 2 == 0) ? 32'h3000 + 4 * (j / 2) : 32'h1100 + 4 * (j / 2));
        gap(ls_rdata, if_rdata);

        // Stray ack while idle must be ignored.
        man_ack = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            check1("idle_ack_ls_ready", ls_ready, 1'b0);
            check1("idle_ack_if_ready", if_ready, 1'b0);
            check1("idle_ack_mem_req", mem_req, 1'b0);
        end
        man_ack = 1'b0;
        do_ls(1'b0, SZ_W, 1'b0, 32'h2200, 32'h0, rd, err, lat, ntx);
        check32("post_idle_ack_latency", lat, 32'd2);
        check32("post_idle_ack_rdata", rd, ref_word(32'h2200));
        gap(rd, if_rdata);

        // Reset while LS busy, then a late ack.
        resp_en = 1'b0;
        ls_req = 1'b1; ls_we = 1'b0; ls_size = SZ_W; ls_unsigned = 1'b0; ls_addr = 32'h2100;
        @(posedge clk); #1;
        check1("rst_mid_req_high", mem_req, 1'b1);
        @(posedge clk); #1;
        check1("rst_mid_req_held", mem_req, 1'b1);
        reset = 1'b1; ls_req = 1'b0;
        @(posedge clk); #1;
        check1("rst_mid_req_low", mem_req, 1'b0);
        check1("rst_mid_no_ready", ls_ready, 1'b0);
        reset = 1'b0; man_ack = 1'b1;
        @(posedge clk); #1;
        man_ack = 1'b0;
        check1("late_ack_no_ready", ls_ready, 1'b0);
        check1("late_ack_mem_req", mem_req, 1'b0);
        @(posedge clk); #1;
        check1("late_ack_no_ready2", ls_ready, 1'b0);
        resp_en = 1'b1;
        do_if(32'h1200, ird, lat);
        check32("post_rst_if_latency", lat, 32'd2);
        check32("post_rst_if_rdata", ird, ref_word(32'h1200));
        gap(ls_rdata, ird);

        // Randomized load/store traffic against the byte-level model.
        for (int unsigned i = 0; i < 200; i++) begin
            logic        we, uns;
            logic [1:0]  sz;
            logic [31:0] a, wd, exp;
            we  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            sz  = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a   = 32'h2000 + $urandom_range(0, 31);
            wd  = $urandom;
            wait_cycles = $urandom_range(0, 2);
            do_ls(we, sz, uns, a, wd, rd, err, lat, ntx);
            exp = '0;
            if (ref_err(sz, a)) begin
                check1("rnd_err", err, 1'b1);
                check32("rnd_err_rdata", rd, 32'h0);
                check32("rnd_err_latency", lat, 32'd1);
                check32("rnd_err_txns", ntx, 32'd0);
            end else begin
                check1("rnd_err", err, 1'b0);
                check32("rnd_latency", lat, 2 + wait_cycles);
                check32("rnd_txns", ntx, 32'd1);
                check32("rnd_be", {28'b0, last_be}, {28'b0, ref_be(sz, a)});
                check32("rnd_addr", last_addr, a & 32'hFFFF_FFFC);
                check1("rnd_we", last_we, we);
                if (we) begin
                    check32("rnd_wdata", last_wdata & be_mask(ref_be(sz, a)), ref_lane(sz, a, wd));
                    check32("rnd_store_rdata", rd, 32'h0);
                    ref_store(sz, a, wd);
                end else begin
                    exp = ref_load(sz, uns, a);
                    check32("rnd_load_rdata", rd, exp);
                end
            end
            gap(exp, if_rdata);
        end
        wait_cycles = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
